// File: rtl/onehot_grant_scheduler_if.sv
// Bundle of requester-side signals for onehot_grant_scheduler.
// The master modport belongs to the requester array, the slave modport to the scheduler.
interface onehot_grant_scheduler_if #(
  parameter int NREQ = 10,
  parameter int ID_W = 4
);
  logic [NREQ-1:0] req;
  logic            done;
  logic [NREQ-1:0] grant;
  logic [ID_W-1:0] grant_id;
  logic            grant_valid;
  logic            timeout;

  modport master (
    output req, done,
    input  grant, grant_id, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_id, grant_valid, timeout
  );
endinterface

// File: rtl/onehot_grant_scheduler.sv
// Round-robin scheduler that hands one shared resource to NREQ requesters in turn,
// holding each grant until done, request drop, or MAX_HOLD busy cycles elapse.
module onehot_grant_scheduler #(
  parameter int NREQ     = 10,
  parameter int ID_W     = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  onehot_grant_scheduler_if.slave  bus
);

  localparam int              HC_W      = $clog2(MAX_HOLD) + 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NREQ - 1);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t          state_q,       state_d;
  logic [NREQ-1:0] grant_q,       grant_d;
  logic [ID_W-1:0] grant_id_q,    grant_id_d;
  logic            grant_valid_q, grant_valid_d;
  logic            timeout_q,     timeout_d;
  logic [HC_W-1:0] hold_cnt_q,    hold_cnt_d;
  logic [ID_W-1:0] ptr_q,         ptr_d;

  logic [NREQ-1:0] mask_hi;
  logic [NREQ-1:0] req_hi;
  logic [NREQ-1:0] pick;
  logic [NREQ-1:0] win_onehot;
  logic [ID_W-1:0] win_idx;
  logic            owner_req;

  // Rotating priority: requests at or above ptr win first; if none, the
  // lowest-indexed request overall wins, which is the wrap-around case.
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    mask_hi    = '0;
    win_onehot = '0;
    win_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask_hi[i] = (ID_W'(i) >= ptr_q);
    end
    req_hi = bus.req & mask_hi;
    pick   = (|req_hi) ? req_hi : bus.req;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pick[i]) begin
        win_onehot    = '0;
        win_onehot[i] = 1'b1;
        win_idx       = ID_W'(i);
      end
    end
  end

  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    hold_cnt_d    = hold_cnt_q;
    ptr_d         = ptr_q;
    timeout_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (|bus.req) begin
          state_d       = BUSY;
          grant_d       = win_onehot;
          grant_id_d    = win_idx;
          grant_valid_d = 1'b1;
          ptr_d         = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
        end
      end

      BUSY: begin
        // done takes priority over the hold limit, so a done on the last
        // allowed cycle is a normal release with no timeout pulse.
        if (bus.done || !owner_req || (hold_cnt_q == HOLD_LAST)) begin
          state_d       = IDLE;
          grant_d       = '0;
          grant_id_d    = '0;
          grant_valid_d = 1'b0;
          hold_cnt_d    = '0;
          timeout_d     = !bus.done && owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: the asynchronous reset clears every register, including the
  // search pointer, so a reset mid-grant drops ownership immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      hold_cnt_q    <= '0;
      ptr_q         <= '0;
    end else begin
      // NOTE: registers update with non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
      hold_cnt_q    <= hold_cnt_d;
      ptr_q         <= ptr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_id    = grant_id_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

  a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant_q));
  a_valid_matches : assert property (@(posedge clk) disable iff (rst)
    grant_valid_q == (|grant_q));
  a_id_in_range : assert property (@(posedge clk) disable iff (rst)
    grant_id_q <= LAST_ID);
  a_hold_bounded : assert property (@(posedge clk) disable iff (rst)
    hold_cnt_q <= HOLD_LAST);

endmodule

// File: tb/tb_onehot_grant_scheduler.sv
// Scoreboard bench for onehot_grant_scheduler: each driven cycle queues the
// outputs expected after the next edge, which are popped and compared at edge+1.
module tb_onehot_grant_scheduler;

  localparam int NREQ     = 10;
  localparam int ID_W     = 4;
  localparam int MAX_HOLD = 8;

  typedef struct {
    string           tag;
    logic [NREQ-1:0] grant;
    logic [ID_W-1:0] id;
    logic            valid;
    logic            timeout;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  onehot_grant_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

  onehot_grant_scheduler #(
    .NREQ    (NREQ),
    .ID_W    (ID_W),
    .MAX_HOLD(MAX_HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [ID_W-1:0] idx_of(input logic [NREQ-1:0] g);
    logic [ID_W-1:0] r = '0;
    for (int i = 0; i < NREQ; i++) if (g[i]) r = ID_W'(i);
    return r;
  endfunction

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // compare them one time unit after the edge.
  task automatic step(input string tag, input logic [NREQ-1:0] r, input logic d,
                      input logic [NREQ-1:0] eg, input logic eto);
    exp_t e;
    bus.req  = r;
    bus.done = d;
    e.tag     = tag;
    e.grant   = eg;
    e.id      = idx_of(eg);
    e.valid   = |eg;
    e.timeout = eto;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({e.tag, ".grant"},   32'(bus.grant),       32'(e.grant));
    check({e.tag, ".id"},      32'(bus.grant_id),    32'(e.id));
    check({e.tag, ".valid"},   32'(bus.grant_valid), 32'(e.valid));
    check({e.tag, ".timeout"}, 32'(bus.timeout),     32'(e.timeout));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  localparam logic [NREQ-1:0] NONE = '0;

  initial begin
    bus.req  = '0;
    bus.done = 1'b0;
    #2;
    check("rst.grant",   32'(bus.grant),       32'h0);
    check("rst.id",      32'(bus.grant_id),    32'h0);
    check("rst.valid",   32'(bus.grant_valid), 32'h0);
    check("rst.timeout", 32'(bus.timeout),     32'h0);
    do_reset();

    // Single requester 3, then request drop releases.
    step("t1.grant", 10'b0000001000, 1'b0, 10'b0000001000, 1'b0);
    step("t1.drop",  NONE,           1'b0, NONE,           1'b0);

    // Full contention with done every cycle: 0..9 then wrap to 0, bubble between.
    do_reset();
    for (int i = 0; i <= NREQ; i++) begin
      step($sformatf("t2.g%0d", i), 10'h3FF, 1'b1, NREQ'(1) << (i % NREQ), 1'b0);
      step($sformatf("t2.b%0d", i), 10'h3FF, 1'b1, NONE, 1'b0);
    end

    // Grant 8 so the pointer sits at 9, then 9 and 2 compete: 9 first, then 2.
    step("t3.g8",  10'b0100000000, 1'b0, 10'b0100000000, 1'b0);
    step("t3.r8",  NONE,           1'b0, NONE,           1'b0);
    step("t3.g9",  10'b1000000100, 1'b0, 10'b1000000000, 1'b0);
    step("t3.nonowner", 10'b1001100100, 1'b0, 10'b1000000000, 1'b0);
    step("t3.r9",  10'b1000000100, 1'b1, NONE,           1'b0);
    step("t3.g2",  10'b1000000100, 1'b0, 10'b0000000100, 1'b0);
    step("t3.r2",  NONE,           1'b1, NONE,           1'b0);

    // Only req[5] held: MAX_HOLD cycles of grant, timeout pulse, re-grant.
    step("t4.g5", 10'b0000100000, 1'b0, 10'b0000100000, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++)
      step($sformatf("t4.h%0d", i), 10'b0000100000, 1'b0, 10'b0000100000, 1'b0);
    step("t4.to",  10'b0000100000, 1'b0, NONE,           1'b1);
    step("t4.rg5", 10'b0000100000, 1'b0, 10'b0000100000, 1'b0);
    for (int i = 1; i < MAX_HOLD; i++)
      step($sformatf("t4.k%0d", i), 10'b0001100000, 1'b0, 10'b0000100000, 1'b0);
    step("t4.to2", 10'b0001100000, 1'b0, NONE,           1'b1);
    step("t4.g6",  10'b0001100000, 1'b0, 10'b0001000000, 1'b0);
    // done on the last allowed cycle is a normal release.
    for (int i = 1; i < MAX_HOLD; i++)
      step($sformatf("t4.m%0d", i), 10'b0001000000, 1'b0, 10'b0001000000, 1'b0);
    step("t4.donelast", 10'b0001000000, 1'b1, NONE, 1'b0);

    // Request 4 granted, then dropped without done; done in IDLE ignored.
    step("t5.g4",   10'b0000010000, 1'b0, 10'b0000010000, 1'b0);
    step("t5.drop", NONE,           1'b0, NONE,           1'b0);
    step("t5.idle", NONE,           1'b1, NONE,           1'b0);

    // Asynchronous reset while 7 owns the grant.
    step("t6.g7",   10'b0010000000, 1'b0, 10'b0010000000, 1'b0);
    step("t6.hold", 10'b0010000000, 1'b0, 10'b0010000000, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6.async.grant", 32'(bus.grant),       32'h0);
    check("t6.async.id",    32'(bus.grant_id),    32'h0);
    check("t6.async.valid", 32'(bus.grant_valid), 32'h0);
    bus.req = 10'b0010000001;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("t6.g0", 10'b0010000001, 1'b0, 10'b0000000001, 1'b0);

    check("sb.empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
